// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: fetches sequential instruction words ahead of IF into a small FIFO.
// Define PFQ_BYPASS_EN to let a response reach IF in the same cycle when the queue is empty.
module if_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_valid,
    input  logic [31:0] mem_rdata,
    input  logic        cpu_ready,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc_plus_4
);
    localparam int unsigned   PW       = $clog2(DEPTH);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [PW:0]   r_count;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_inst_q [DEPTH];
    logic [31:0]   r_pc_q   [DEPTH];

    logic        w_empty;
    logic        w_resp_keep;
    logic        w_bypass;
    logic        w_push;
    logic        w_pop;
    logic [31:0] w_req_pc;
    logic [31:0] w_redirect_aligned;

    assign w_empty            = (r_count == '0);
    // fetch_pc advanced at issue and cannot move while a kept request is outstanding.
    assign w_req_pc           = r_fetch_pc - 32'd4;
    assign w_redirect_aligned = redirect_pc & ~32'd3;
    assign w_resp_keep        = (r_state == S_WAIT) & mem_valid & ~flush & ~reset;
    assign w_pop              = ~w_empty & cpu_ready;

`ifdef PFQ_BYPASS_EN
    assign w_bypass = w_resp_keep & w_empty;
    assign w_push   = w_resp_keep & ~(w_bypass & cpu_ready);
`else
    assign w_bypass = 1'b0;
    assign w_push   = w_resp_keep;
`endif

    assign mem_req        = (r_state == S_IDLE) & (r_count < CNT_FULL) & ~flush & ~reset;
    assign mem_addr       = r_fetch_pc;
    assign inst_valid     = ~w_empty | w_bypass;
    assign inst           = w_bypass ? mem_rdata : r_inst_q[r_rd_ptr];
    assign inst_pc        = w_bypass ? w_req_pc  : r_pc_q[r_rd_ptr];
    assign inst_pc_plus_4 = inst_pc + 32'd4;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (mem_req) w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (mem_valid)  w_state_nxt = S_IDLE;
                else if (flush) w_state_nxt = S_DROP;
            end
            // The discarded response always retires the request, even under a new flush.
            S_DROP:  if (mem_valid) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_fetch_pc <= RESET_PC;
            // NOTE: storage is cleared so the empty-queue head reads inst=0, pc=0 after reset.
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_inst_q[i] <= '0;
                r_pc_q[i]   <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            if (flush) begin
                r_count    <= '0;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_fetch_pc <= w_redirect_aligned;
            end else begin
                if (mem_req) r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_push) begin
                    r_inst_q[r_wr_ptr] <= mem_rdata;
                    r_pc_q[r_wr_ptr]   <= w_req_pc;
                    r_wr_ptr           <= r_wr_ptr + PTR_ONE;
                end
                if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_ONE;
                    2'b01:   r_count <= r_count - CNT_ONE;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // A response with nothing outstanding is a memory protocol error.
    a_no_stray_resp: assert property (@(posedge clock) disable iff (reset)
        !(mem_valid && (r_state == S_IDLE)));

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Bench for if_prefetch_queue: directed table, corner-case sequences and randomized traffic
// against a queue-based reference model with a variable-latency memory.
module tb_if_prefetch_queue;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef PFQ_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic [31:0] mem_rdata;
    logic        cpu_ready;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc_plus_4;

    always #5 clock = ~clock;

    if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clock(clock), .reset(reset),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_valid(mem_valid), .mem_rdata(mem_rdata),
        .cpu_ready(cpu_ready), .flush(flush), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_pc_plus_4(inst_pc_plus_4)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Memory model: one outstanding request, answered m_lat cycles after issue.
    bit          m_busy = 1'b0;
    int          m_timer = 0;
    int          m_lat = 2;
    bit          rand_lat = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] req_log[$];

    // Table mode: the vector supplies the memory response instead of the model.
    bit          tbl_mode = 1'b0;
    bit          tbl_mv = 1'b0;
    logic [31:0] tbl_maddr = '0;

    // Reference model: fetched words in order, plus one outstanding fetch.
    typedef struct packed { logic [31:0] w; logic [31:0] pc; } ent_t;
    ent_t        mq[$];
    bit          o_busy = 1'b0;
    bit          o_keep = 1'b0;
    logic [31:0] o_addr = '0;
    logic [31:0] nxt_pc = RESET_PC;
    bit          e_req, e_byp, e_iv;
    logic [31:0] e_inst, e_pc;

    logic        obs_req, obs_iv;
    logic [31:0] obs_addr, obs_inst, obs_pc, obs_pc4;

    task automatic step(input bit rst, input bit fl, input logic [31:0] rpc,
                        input bit rdy, input bit chk);
        reset = rst; flush = fl; redirect_pc = rpc; cpu_ready = rdy;
        if (tbl_mode) begin
            mem_valid = tbl_mv;
            mem_rdata = tbl_mv ? data_of(tbl_maddr) : $urandom();
        end else begin
            mem_valid = m_busy && (m_timer == 1);
            mem_rdata = mem_valid ? data_of(m_addr) : $urandom();
        end
        #1;
        obs_req = mem_req; obs_addr = mem_addr; obs_iv = inst_valid;
        obs_inst = inst; obs_pc = inst_pc; obs_pc4 = inst_pc_plus_4;

        e_req  = !rst && !fl && !o_busy && (mq.size() < DEPTH);
        e_byp  = BYPASS && !rst && !fl && o_busy && o_keep && mem_valid && (mq.size() == 0);
        e_iv   = (mq.size() != 0) || e_byp;
        e_inst = '0;
        e_pc   = '0;
        if (e_byp) begin
            e_inst = mem_rdata; e_pc = o_addr;
        end else if (mq.size() != 0) begin
            e_inst = mq[0].w; e_pc = mq[0].pc;
        end
        if (chk) begin
            check("mem_req", 32'(obs_req), 32'(e_req));
            if (e_req) check("mem_addr", obs_addr, nxt_pc);
            check("inst_valid", 32'(obs_iv), 32'(e_iv));
            if (e_iv) begin
                check("inst", obs_inst, e_inst);
                check("inst_pc", obs_pc, e_pc);
                check("inst_pc_plus_4", obs_pc4, e_pc + 32'd4);
            end
        end

        @(posedge clock);
        if (rst) begin
            mq.delete(); o_busy = 1'b0; nxt_pc = RESET_PC;
        end else if (fl) begin
            mq.delete();
            if (o_busy) begin
                if (mem_valid) o_busy = 1'b0;
                else o_keep = 1'b0;
            end
            nxt_pc = {rpc[31:2], 2'b00};
        end else begin
            if ((mq.size() != 0) && rdy) void'(mq.pop_front());
            if (o_busy && mem_valid) begin
                if (o_keep && !(e_byp && rdy)) mq.push_back('{w: mem_rdata, pc: o_addr});
                o_busy = 1'b0;
            end
            if (e_req) begin
                o_busy = 1'b1; o_keep = 1'b1; o_addr = nxt_pc; nxt_pc = nxt_pc + 32'd4;
            end
        end

        if (!tbl_mode && m_busy) begin
            if (mem_valid) m_busy = 1'b0;
            else m_timer--;
        end
        if (rst) m_busy = 1'b0;
        if (obs_req) begin
            req_log.push_back(obs_addr);
            if (!tbl_mode) begin
                m_busy = 1'b1; m_addr = obs_addr;
                m_lat = rand_lat ? int'($urandom_range(1, 4)) : 2;
                m_timer = m_lat;
            end
        end
        @(negedge clock);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        req_log.delete();
    endtask

    typedef struct {
        bit mv; logic [31:0] maddr;
        bit req; logic [31:0] raddr;
        bit iv; logic [31:0] pc;
    } vec_t;
    vec_t vecs[13];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit r_rst, r_fl, r_rdy;
        logic [31:0] r_pc;
        reset = 1'b1; flush = 1'b0; redirect_pc = '0; cpu_ready = 1'b0;
        mem_valid = 1'b0; mem_rdata = '0;
        @(negedge clock);

        // Reset, 2-cycle memory, cpu_ready held high (cycles 1..13 after reset).
        vecs = '{
            '{1'b0, 32'h0, 1'b1, 32'h0,  1'b0,    32'h0},
            '{1'b0, 32'h0, 1'b0, 32'h0,  1'b0,    32'h0},
            '{1'b1, 32'h0, 1'b0, 32'h0,  BYPASS,  32'h0},
            '{1'b0, 32'h0, 1'b1, 32'h4,  !BYPASS, 32'h0},
            '{1'b0, 32'h0, 1'b0, 32'h0,  1'b0,    32'h0},
            '{1'b1, 32'h4, 1'b0, 32'h0,  BYPASS,  32'h4},
            '{1'b0, 32'h0, 1'b1, 32'h8,  !BYPASS, 32'h4},
            '{1'b0, 32'h0, 1'b0, 32'h0,  1'b0,    32'h0},
            '{1'b1, 32'h8, 1'b0, 32'h0,  BYPASS,  32'h8},
            '{1'b0, 32'h0, 1'b1, 32'hC,  !BYPASS, 32'h8},
            '{1'b0, 32'h0, 1'b0, 32'h0,  1'b0,    32'h0},
            '{1'b1, 32'hC, 1'b0, 32'h0,  BYPASS,  32'hC},
            '{1'b0, 32'h0, 1'b1, 32'h10, !BYPASS, 32'hC}
        };
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        tbl_mode = 1'b1;
        foreach (vecs[i]) begin
            tbl_mv = vecs[i].mv; tbl_maddr = vecs[i].maddr;
            step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
            if (i == 0) begin
                check("rst_inst", obs_inst, 32'h0);
                check("rst_pc", obs_pc, 32'h0);
                check("rst_pc4", obs_pc4, 32'h4);
            end
            check("tbl_req", 32'(obs_req), 32'(vecs[i].req));
            if (vecs[i].req) check("tbl_addr", obs_addr, vecs[i].raddr);
            check("tbl_iv", 32'(obs_iv), 32'(vecs[i].iv));
            if (vecs[i].iv) begin
                check("tbl_pc", obs_pc, vecs[i].pc);
                check("tbl_pc4", obs_pc4, vecs[i].pc + 32'd4);
                check("tbl_inst", obs_inst, data_of(vecs[i].pc));
            end
        end
        tbl_mode = 1'b0;

        // Stalled pipeline fills the queue, one pop reopens issue at 0x10.
        do_reset();
        repeat (16) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("full_nreq", 32'(req_log.size()), 32'd4);
        foreach (req_log[i]) check("full_addr", req_log[i], 32'(i * 4));
        check("full_noreq", 32'(obs_req), 32'd0);
        check("full_iv", 32'(obs_iv), 32'd1);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check("full_pop_pc", obs_pc, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("after_pop_req", 32'(obs_req), 32'd1);
        check("after_pop_addr", obs_addr, 32'h10);

        // Flush while waiting on 0x8: stale word dropped, refetch from 0x100.
        do_reset();
        n = 0;
        while (req_log.size() < 3 && n < 30) begin
            step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1); n++;
        end
        check("drop_reach_8", 32'(req_log.size()), 32'd3);
        step(1'b0, 1'b1, 32'h103, 1'b1, 1'b1);
        check("drop_flush_noreq", 32'(obs_req), 32'd0);
        n = 0;
        do begin
            step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1); n++;
        end while (!obs_req && n < 20);
        check("drop_gap", 32'(n), 32'd2);
        check("drop_addr", obs_addr, 32'h100);
        n = 0;
        while (!obs_iv && n < 20) begin
            step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1); n++;
        end
        check("drop_first_iv", 32'(obs_iv), 32'd1);
        check("drop_first_pc", obs_pc, 32'h100);

        // Flush coincident with a response, then push and pop in the same cycle.
        do_reset();
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 32'h200, 1'b0, 1'b1);
        check("fmv_noreq", 32'(obs_req), 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("fmv_empty", 32'(obs_iv), 32'd0);
        check("fmv_req", 32'(obs_req), 32'd1);
        check("fmv_addr", obs_addr, 32'h200);
        repeat (4) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check("pp_pc", obs_pc, 32'h200);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("pp_iv", 32'(obs_iv), 32'd1);
        check("pp_pc_next", obs_pc, 32'h204);

        // Fetch address wraps from the top of the address space.
        do_reset();
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("wrap_nreq", 32'(req_log.size()), 32'd2);
        if (req_log.size() >= 2) begin
            check("wrap_addr0", req_log[0], 32'hFFFF_FFFC);
            check("wrap_addr1", req_log[1], 32'h0);
        end
        check("wrap_pc", obs_pc, 32'hFFFF_FFFC);
        check("wrap_pc4", obs_pc4, 32'h0);

        // Reset in the middle of a wait with three entries queued.
        do_reset();
        repeat (10) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("mid_nreq", 32'(req_log.size()), 32'd4);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("mid_iv", 32'(obs_iv), 32'd0);
        check("mid_inst", obs_inst, 32'h0);
        check("mid_req", 32'(obs_req), 32'd1);
        check("mid_addr", obs_addr, RESET_PC);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("mid_resp_iv", 32'(obs_iv), 32'(BYPASS));
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("mid_next_iv", 32'(obs_iv), 32'd1);
        check("mid_next_pc", obs_pc, RESET_PC);

        // Randomized traffic: variable latency, stalls, redirects and occasional reset.
        rand_lat = 1'b1;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            r_rst = ($urandom_range(0, 99) == 0);
            r_fl  = ($urandom_range(0, 15) == 0);
            r_rdy = ($urandom_range(0, 3) != 0);
            r_pc  = $urandom();
            if ($urandom_range(0, 3) == 0) r_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            step(r_rst, r_fl, r_pc, r_rdy, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
